// File: rtl/snake_screen_arbiter_if.sv
// Pixel and control bus between the snake engine side and the screen arbiter.
// The arbiter takes the slave view; the engine/testbench drives the master view.
interface snake_screen_arbiter_if;
  logic [7:0] snake_x;
  logic [6:0] snake_y;
  logic [2:0] snake_colour;
  logic       snake_plot;
  logic       is_dead;
  logic       start;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       snake_hold_n;
  logic [2:0] state_out;

  modport master (
    output snake_x, snake_y, snake_colour, snake_plot, is_dead, start,
    input  vga_x, vga_y, vga_colour, vga_plot, snake_hold_n, state_out
  );

  modport slave (
    input  snake_x, snake_y, snake_colour, snake_plot, is_dead, start,
    output vga_x, vga_y, vga_colour, vga_plot, snake_hold_n, state_out
  );
endinterface

// File: rtl/snake_screen_arbiter.sv
// Owns the VGA pixel bus: clears the screen, forwards engine pixels during play,
// and floods the screen on death; holds the engine in reset when it must not draw.
module snake_screen_arbiter #(
  parameter int unsigned WIDTH        = 160,
  parameter int unsigned HEIGHT       = 120,
  parameter logic [2:0]  CLEAR_COLOUR = 3'b000,
  parameter logic [2:0]  DEAD_COLOUR  = 3'b100,
  parameter logic [31:0] DEAD_DELAY   = 32'd50_000_000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  snake_screen_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    CLEAR     = 3'd0,
    PLAY      = 3'd1,
    DEAD_WAIT = 3'd2,
    DEAD_FILL = 3'd3,
    GAME_OVER = 3'd4
  } state_e;

  localparam logic [7:0]  X_LAST   = 8'(WIDTH - 1);
  localparam logic [6:0]  Y_LAST   = 7'(HEIGHT - 1);
  localparam logic [31:0] DLY_LOAD = DEAD_DELAY - 32'd1;

  state_e      state_q, state_d;
  logic [7:0]  x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic [31:0] dly_q, dly_d;
  logic [7:0]  vx_q, vx_d;
  logic [6:0]  vy_q, vy_d;
  logic [2:0]  vc_q, vc_d;
  logic        plot_q, plot_d;
  logic        hold_q, hold_d;

  logic x_wrap;
  logic sweep_last;

  assign x_wrap     = (x_q == X_LAST);
  assign sweep_last = x_wrap && (y_q == Y_LAST);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dly_d   = dly_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    vc_d    = vc_q;
    plot_d  = 1'b0;
    hold_d  = 1'b0;
    case (state_q)
      CLEAR, DEAD_FILL: begin
        // Both sweeps share the raster walk; only colour and exit state differ.
        vx_d   = x_q;
        vy_d   = y_q;
        vc_d   = (state_q == CLEAR) ? CLEAR_COLOUR : DEAD_COLOUR;
        plot_d = 1'b1;
        if (x_wrap) begin
          x_d = 8'd0;
          y_d = sweep_last ? 7'd0 : y_q + 7'd1;
        end else begin
          x_d = x_q + 8'd1;
        end
        if (sweep_last) begin
          state_d = (state_q == CLEAR) ? PLAY : GAME_OVER;
        end
      end
      PLAY: begin
        vx_d   = bus.snake_x;
        vy_d   = bus.snake_y;
        vc_d   = bus.snake_colour;
        plot_d = bus.snake_plot;
        hold_d = 1'b1;
        // The pixel arriving alongside the death flag is still forwarded.
        if (bus.is_dead) begin
          state_d = DEAD_WAIT;
          dly_d   = DLY_LOAD;
          hold_d  = 1'b0;
        end
      end
      DEAD_WAIT: begin
        if (dly_q == 32'd0) begin
          state_d = DEAD_FILL;
        end else begin
          dly_d = dly_q - 32'd1;
        end
      end
      GAME_OVER: begin
        if (bus.start) begin
          state_d = CLEAR;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      x_q     <= 8'd0;
      y_q     <= 7'd0;
      dly_q   <= 32'd0;
      vx_q    <= 8'd0;
      vy_q    <= 7'd0;
      vc_q    <= 3'd0;
      plot_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dly_q   <= dly_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      vc_q    <= vc_d;
      plot_q  <= plot_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.vga_x        = vx_q;
  assign bus.vga_y        = vy_q;
  assign bus.vga_colour   = vc_q;
  assign bus.vga_plot     = plot_q;
  assign bus.snake_hold_n = hold_q;
  assign bus.state_out    = state_q;

endmodule
